// File: rtl/windowed_sample_capture.sv
// Multi-channel windowed capture buffer: skips D sample strobes after start,
// stores the next N strobes per channel, then streams the rows out over valid/ready.
module windowed_sample_capture #(
  parameter int W  = 16,
  parameter int CH = 2,
  parameter int N  = 6,
  parameter int D  = 3,
  parameter int CW = 16,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            sample_en,
  input  logic [CH*W-1:0] din,
  output logic [CH*W-1:0] rd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [IW-1:0]   rd_index,
  output logic            rd_last,
  output logic            busy,
  output logic            cap_done
);

  localparam int            DW       = CH * W;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] D_LAST   = CW'((D > 0) ? (D - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] dcnt_r, dcnt_nxt_s;
  logic [IW-1:0] widx_r, widx_nxt_s;
  logic [IW-1:0] ridx_r, ridx_nxt_s;
  logic          wr_en_s;
  logic [DW-1:0] mem_r [N];
  logic [DW-1:0] row_nxt_s;
  logic          rd_valid_r, rd_last_r, busy_r, cap_done_r;
  logic [IW-1:0] rd_index_r;
  logic [DW-1:0] rd_data_r;

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign rd_index = rd_index_r;
  assign rd_last  = rd_last_r;
  assign busy     = busy_r;
  assign cap_done = cap_done_r;

  // Next-state, counter and write-enable decode; abort overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    dcnt_nxt_s  = dcnt_r;
    widx_nxt_s  = widx_r;
    ridx_nxt_s  = ridx_r;
    wr_en_s     = 1'b0;
    if (abort) begin
      state_nxt_s = ST_IDLE;
      dcnt_nxt_s  = '0;
      widx_nxt_s  = '0;
      ridx_nxt_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            dcnt_nxt_s  = '0;
            widx_nxt_s  = '0;
            ridx_nxt_s  = '0;
            state_nxt_s = (D > 0) ? ST_DELAY : ST_CAPTURE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (sample_en) begin
            dcnt_nxt_s = dcnt_r + CW'(1);
            if (dcnt_r == D_LAST) begin
              state_nxt_s = ST_CAPTURE;
              widx_nxt_s  = '0;
            end else begin
              state_nxt_s = ST_DELAY;
            end
          end else begin
            state_nxt_s = ST_DELAY;
          end
        end
        ST_CAPTURE: begin
          if (sample_en) begin
            wr_en_s = 1'b1;
            if (widx_r == LAST_IDX) begin
              state_nxt_s = ST_READOUT;
              widx_nxt_s  = '0;
              ridx_nxt_s  = '0;
            end else begin
              widx_nxt_s = widx_r + IW'(1);
            end
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end
        ST_READOUT: begin
          if (rd_valid_r && rd_ready) begin
            if (ridx_r == LAST_IDX) begin
              state_nxt_s = ST_IDLE;
              ridx_nxt_s  = '0;
            end else begin
              ridx_nxt_s = ridx_r + IW'(1);
            end
          end else begin
            state_nxt_s = ST_READOUT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          dcnt_nxt_s  = '0;
          widx_nxt_s  = '0;
          ridx_nxt_s  = '0;
        end
      endcase
    end
  end

  // Row about to be presented; bypass covers a row written in the same cycle (N == 1).
  always_comb begin
    row_nxt_s = mem_r[ridx_nxt_s];
    if (wr_en_s && (widx_r == ridx_nxt_s)) begin
      row_nxt_s = din;
    end else begin
      row_nxt_s = mem_r[ridx_nxt_s];
    end
  end

  // State, counters and registered readout outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      dcnt_r     <= '0;
      widx_r     <= '0;
      ridx_r     <= '0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_index_r <= '0;
      rd_data_r  <= '0;
      busy_r     <= 1'b0;
      cap_done_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      dcnt_r     <= dcnt_nxt_s;
      widx_r     <= widx_nxt_s;
      ridx_r     <= ridx_nxt_s;
      rd_valid_r <= (state_nxt_s == ST_READOUT);
      rd_last_r  <= (state_nxt_s == ST_READOUT) && (ridx_nxt_s == LAST_IDX);
      rd_index_r <= (state_nxt_s == ST_READOUT) ? ridx_nxt_s : '0;
      rd_data_r  <= (state_nxt_s == ST_READOUT) ? row_nxt_s : rd_data_r;
      busy_r     <= (state_nxt_s != ST_IDLE);
      cap_done_r <= (state_r == ST_CAPTURE) && (state_nxt_s == ST_READOUT);
    end
  end

  // Sample buffer; contents survive abort and are only overwritten by a new window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[widx_r] <= din;
    end
  end

endmodule

// File: tb/tb_windowed_sample_capture.sv
// Scoreboard bench for windowed_sample_capture: D=3 main instance plus a D=0 instance.
module tb_windowed_sample_capture;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
  } row_t;

  logic        clk, rst_n, start, abort, sample_en, rd_ready;
  logic [31:0] din;
  logic [31:0] rd_data, rd_data_z;
  logic        rd_valid, rd_last, busy, cap_done;
  logic        rd_valid_z, rd_last_z, busy_z, cap_done_z;
  logic [2:0]  rd_index, rd_index_z;

  int   total = 0;
  int   bad   = 0;
  int   capcnt = 0;
  int   xfer   = 0;
  bit   chk0   = 1'b0;
  row_t q[$];
  row_t q0[$];

  bit          stall_p = 1'b0;
  logic [31:0] hold_data;
  logic [2:0]  hold_idx;
  logic        hold_last;

  windowed_sample_capture #(.W(16), .CH(2), .N(6), .D(3), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sample_en(sample_en),
    .din(din), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_index(rd_index), .rd_last(rd_last), .busy(busy), .cap_done(cap_done)
  );

  windowed_sample_capture #(.W(16), .CH(2), .N(6), .D(0), .CW(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sample_en(sample_en),
    .din(din), .rd_data(rd_data_z), .rd_valid(rd_valid_z), .rd_ready(rd_ready),
    .rd_index(rd_index_z), .rd_last(rd_last_z), .busy(busy_z), .cap_done(cap_done_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int v);
    logic [15:0] lo, hi;
    lo = 16'(v);
    hi = 16'(-v);
    return {hi, lo};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input int v, input int i);
    row_t r;
    r.data = pat(v);
    r.idx  = 3'(i);
    r.last = (i == 5);
    q.push_back(r);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy && !rd_valid) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic run_window(input int base, input int nstrobe);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= nstrobe; k++) begin
      sample_en = 1'b1;
      din = pat(base + k);
      if (k >= 4 && k <= 9) push_row(base + k, k - 4);
      tick;
    end
    sample_en = 1'b0;
  endtask

  // Scoreboard monitor for the D=3 instance: pops on every transfer, checks stall hold.
  always @(negedge clk) begin : mon
    row_t e;
    if (!rst_n) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        total++;
        if (rd_valid !== 1'b1 || rd_data !== hold_data || rd_index !== hold_idx || rd_last !== hold_last) begin
          bad++;
          $display("FAIL stall_hold: got v=%0b d=%h i=%0d l=%0b want v=1 d=%h i=%0d l=%0b",
                   rd_valid, rd_data, rd_index, rd_last, hold_data, hold_idx, hold_last);
        end
      end
      stall_p   = rd_valid && !rd_ready;
      hold_data = rd_data;
      hold_idx  = rd_index;
      hold_last = rd_last;
      if (cap_done === 1'b1) capcnt++;
      if (rd_valid && rd_ready) begin
        xfer++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_row: got d=%h i=%0d want no transfer", rd_data, rd_index);
        end else begin
          e = q.pop_front();
          if (rd_data !== e.data || rd_index !== e.idx || rd_last !== e.last) begin
            bad++;
            $display("FAIL row: got d=%h i=%0d l=%0b want d=%h i=%0d l=%0b",
                     rd_data, rd_index, rd_last, e.data, e.idx, e.last);
          end
        end
      end
    end
  end

  // Scoreboard monitor for the D=0 instance, active only during its scenario.
  always @(negedge clk) begin : mon0
    row_t e;
    if (rst_n && chk0 && rd_valid_z && rd_ready) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL d0_unexpected_row: got d=%h i=%0d want no transfer", rd_data_z, rd_index_z);
      end else begin
        e = q0.pop_front();
        if (rd_data_z !== e.data || rd_index_z !== e.idx || rd_last_z !== e.last) begin
          bad++;
          $display("FAIL d0_row: got d=%h i=%0d l=%0b want d=%h i=%0d l=%0b",
                   rd_data_z, rd_index_z, rd_last_z, e.data, e.idx, e.last);
        end
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sample_en = 1'b0; rd_ready = 1'b1; din = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rd_valid, rd_last, busy, cap_done, rd_index, rd_data} !== 39'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b l=%0b b=%0b c=%0b i=%0d d=%h want all 0",
               rd_valid, rd_last, busy, cap_done, rd_index, rd_data);
    end
    total++;
    if ({rd_valid_z, busy_z, cap_done_z} !== 3'd0) begin
      bad++;
      $display("FAIL reset_d0: got v=%0b b=%0b c=%0b want 0", rd_valid_z, busy_z, cap_done_z);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_continuous;
    row_t r;
    bit   ok;
    capcnt = 0; xfer = 0; chk0 = 1'b1; rd_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      sample_en = 1'b1;
      din = pat(k);
      if (k >= 4 && k <= 9) push_row(k, k - 4);
      if (k <= 6) begin
        r.data = pat(k); r.idx = 3'(k - 1); r.last = (k == 6);
        q0.push_back(r);
      end
      tick;
      if (k == 8 || k == 9) begin
        @(negedge clk);
        total++;
        if (rd_valid !== (k == 9) || cap_done !== (k == 9)) begin
          bad++;
          $display("FAIL first_row_latency: k=%0d got v=%0b c=%0b want %0b", k, rd_valid, cap_done, (k == 9));
        end
      end
    end
    sample_en = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL cont_idle: got busy=%0b q=%0d want idle", busy, q.size()); end
    total++;
    if (capcnt !== 1) begin bad++; $display("FAIL cont_capdone: got %0d want 1", capcnt); end
    total++;
    if (xfer !== 6) begin bad++; $display("FAIL cont_xfers: got %0d want 6", xfer); end
    total++;
    if (q0.size() !== 0 || busy_z !== 1'b0) begin
      bad++;
      $display("FAIL d0_done: got left=%0d busy=%0b want 0 0", q0.size(), busy_z);
    end
    chk0 = 1'b0;
  endtask

  task automatic test_stall;
    logic [3:0] rdy_pat;
    bit ok;
    rdy_pat = 4'b1001;
    xfer = 0; capcnt = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      rd_ready  = rdy_pat[cyc % 4];
      start     = (cyc == 0);
      sample_en = (cyc >= 1 && cyc <= 9);
      din       = pat(100 + cyc);
      if (cyc >= 4 && cyc <= 9) push_row(100 + cyc, cyc - 4);
      tick;
      if (cyc > 12 && !busy && q.size() == 0) break;
    end
    start = 1'b0; sample_en = 1'b0; rd_ready = 1'b1;
    wait_idle(ok);
    total++;
    if (!ok || xfer !== 6) begin bad++; $display("FAIL stall_xfers: got %0d ok=%0b want 6", xfer, ok); end
    total++;
    if (capcnt !== 1) begin bad++; $display("FAIL stall_capdone: got %0d want 1", capcnt); end
  endtask

  task automatic test_gaps;
    bit ok;
    xfer = 0; rd_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      sample_en = 1'b0;
      repeat (2 + $urandom_range(0, 2)) begin
        din = $urandom;
        tick;
      end
      sample_en = 1'b1;
      din = pat(50 + k);
      if (k >= 4) push_row(50 + k, k - 4);
      tick;
    end
    sample_en = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok || xfer !== 6) begin bad++; $display("FAIL gaps_xfers: got %0d ok=%0b want 6", xfer, ok); end
  endtask

  task automatic test_restart;
    bit ok;
    xfer = 0; rd_ready = 1'b1;
    start = 1'b1;
    tick;
    for (int k = 1; k <= 9; k++) begin
      start = (k == 6);
      sample_en = 1'b1;
      din = pat(150 + k);
      if (k >= 4) push_row(150 + k, k - 4);
      tick;
    end
    sample_en = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_idle(ok);
    repeat (3) tick;
    total++;
    if (!ok || xfer !== 6 || busy !== 1'b0) begin
      bad++;
      $display("FAIL restart_ignored: got xfers=%0d busy=%0b want 6 0", xfer, busy);
    end
    xfer = 0;
    run_window(200, 9);
    wait_idle(ok);
    total++;
    if (!ok || xfer !== 6) begin bad++; $display("FAIL fresh_window: got %0d want 6", xfer); end
  endtask

  task automatic test_abort_reset;
    bit ok;
    capcnt = 0; rd_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sample_en = 1'b1; din = pat(500 + k);
      tick;
    end
    abort = 1'b1; start = 1'b1; sample_en = 1'b1;
    tick;
    abort = 1'b0; start = 1'b0; sample_en = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: got busy=%0b v=%0b want 0 0", busy, rd_valid);
    end
    repeat (3) tick;
    total++;
    if (capcnt !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_capdone: got cap=%0d busy=%0b want 0 0", capcnt, busy);
    end
    run_window(300, 9);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_valid && rd_index == 3'd3) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL reach_row3: got idx=%0d want 3", rd_index); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({rd_valid, rd_last, busy, cap_done, rd_index, rd_data} !== 39'd0) begin
      bad++;
      $display("FAIL midread_reset: got v=%0b l=%0b b=%0b c=%0b i=%0d d=%h want all 0",
               rd_valid, rd_last, busy, cap_done, rd_index, rd_data);
    end
    q.delete();
    tick;
    rst_n = 1'b1;
    tick;
    xfer = 0; capcnt = 0;
    run_window(400, 9);
    wait_idle(ok);
    total++;
    if (!ok || xfer !== 6 || capcnt !== 1) begin
      bad++;
      $display("FAIL post_reset_window: got xfers=%0d cap=%0d want 6 1", xfer, capcnt);
    end
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_stall;
    test_gaps;
    test_restart;
    test_abort_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/windowed_sample_capture.md
Name: windowed_sample_capture

Overview:
- Multi-channel windowed sample capture buffer. After `start`, it discards the first D sample strobes and stores the next N strobes per channel in a register array.
- It then streams the stored samples out over a valid/ready interface.
- Generalises the single-channel, fixed-window delay-line tap. Adds a self-owned window counter, channel count, fixed-point sample width, an abort and a readout handshake.
- Sits between the sample front end (tap chain / ADC model) and downstream processing.

Parameters:
- W, 16: bits per channel sample (signed two's complement fixed point).
- CH, 2: number of channels captured in lockstep.
- N, 6: samples captured per channel per window (N >= 1).
- D, 3: sample strobes discarded after start before capture begins (D >= 0).
- CW, 16: width of the internal delay counter (2^CW > D).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to arm a capture window; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- sample_en  in  1  sample strobe; din is valid this cycle.
- din  in  CH*W  channel samples, channel c at bits [c*W +: W].
- rd_data  out  CH*W  stored sample row rd_index, same channel packing as din.
- rd_valid  out  1  rd_data/rd_index/rd_last valid.
- rd_ready  in  1  consumer accepts the current row.
- rd_index  out  max(1,$clog2(N))  sample index of the current row, 0..N-1.
- rd_last  out  1  high with rd_valid when rd_index == N-1.
- busy  out  1  high in every state except IDLE.
- cap_done  out  1  one-cycle pulse on entry to READOUT.

Behaviour:
- Single clock domain; clk and rst_n only. rst_n is asynchronous, active-low.
- Reset: state=IDLE, all counters 0, rd_valid=0, rd_last=0, busy=0, cap_done=0, rd_index=0, rd_data=0.
- Buffer contents are cleared to 0 on reset.
- FSM has four states: IDLE, DELAY, CAPTURE, READOUT.
- IDLE:
  - start=1 -> DELAY with dcnt=0 when D>0; -> CAPTURE with widx=0 when D==0.
  - sample_en is ignored in IDLE.
- DELAY:
  - Each cycle with sample_en=1 increments dcnt.
  - sample_en=1 with dcnt==D-1 -> CAPTURE. That strobe is discarded, not captured.
- CAPTURE:
  - sample_en=1 writes din to mem[widx] and increments widx.
  - sample_en=1 with widx==N-1 writes the last row and goes to READOUT next cycle, with ridx=0.
  - cap_done pulses for exactly the first READOUT cycle.
- Strobe gaps (sample_en=0) stall DELAY/CAPTURE indefinitely and lose no state.
- READOUT:
  - rd_valid=1, rd_data=mem[ridx], rd_index=ridx, rd_last=(ridx==N-1).
  - Transfer occurs on rd_valid & rd_ready, then ridx increments.
  - Transfer with rd_last -> IDLE. rd_valid=0 from the next cycle.
  - While rd_valid & !rd_ready, rd_data, rd_index and rd_last hold stable.
  - sample_en is ignored during READOUT.
- Total latency: N rows appear after exactly D+N accepted strobes. The first row is valid the cycle after the last capturing strobe.
- start outside IDLE is ignored, with no restart and no queuing.
- abort=1 in any state:
  - -> IDLE next cycle; rd_valid drops next cycle; no cap_done.
  - Buffer contents are left as is; a new start overwrites them.
  - abort takes priority over start, sample_en and rd_ready in the same cycle.
- Reset asserted mid-window or mid-readout forces the reset values immediately (asynchronous).
- Samples are stored bit-exact; no arithmetic, truncation or sign extension.
- Each channel's bit slice is stored independently.

Test Plan:
- D=3,N=6,CH=2, continuous sample_en, din ch0=k, ch1=-k for k=1..12, rd_ready=1 -> rows 0..5 carry ch0=4..9, ch1=-4..-9; cap_done one cycle; rd_last only on row 5; busy falls after row 5.
- D=0,N=6 -> first strobe after start (k=1) captured as row 0; rows are 1..6.
- rd_ready toggling 1,0,0,1 pattern -> no row skipped or duplicated; rd_data stable during stalls; exactly 6 transfers.
- sample_en every third cycle with random gaps -> same captured values as the continuous case; no extra strobes consumed.
- start pulsed again during CAPTURE and READOUT -> ignored; row sequence unchanged. start in IDLE after completion -> new window with fresh data.
- abort in CAPTURE after 2 rows; rst_n low during READOUT row 3 -> IDLE next cycle / immediately, rd_valid=0, no cap_done. Subsequent start captures correctly.
